// File: rtl/floor_access_controller.sv
// Request sequencer for the two-floor parking access system.
// Walks each enter/exit request through evaluation, an optional
// alternative-floor offer, and a commit or deny. It also owns the three
// free-space counters. Every output is registered from next-state values, so
// the outputs line up with the state they describe.
module floor_access_controller #(
    parameter int FLR0_NORM_CAP = 3,
    parameter int FLR0_SPEC_CAP = 2,
    parameter int FLR1_CAP      = 3,
    parameter int CNT_W         = 3,
    parameter int TIMEOUT_CYC   = 255
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       MODE,
    input  logic             submit,
    input  logic             chosen_flr,
    input  logic             id_valid,
    input  logic             id_special,
    input  logic             chosen_flr_full,
    input  logic             alternative_flr_full,
    input  logic             exit_flr,
    input  logic             accept_alt,
    input  logic             decline,
    output logic [1:0]       action_taken,
    output logic [CNT_W-1:0] remain_flr_spec_0,
    output logic [CNT_W-1:0] remain_flr_norm_0,
    output logic [CNT_W-1:0] remain_flr_1,
    output logic             offer_alt,
    output logic             denied,
    output logic             done,
    output logic             busy
);

    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] SPEC_CAP = CNT_W'(FLR0_SPEC_CAP);
    localparam logic [CNT_W-1:0] NORM_CAP = CNT_W'(FLR0_NORM_CAP);
    localparam logic [CNT_W-1:0] F1_CAP   = CNT_W'(FLR1_CAP);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    localparam logic [1:0] ACT_NONE   = 2'd0;
    localparam logic [1:0] ACT_ALT    = 2'd1;
    localparam logic [1:0] ACT_CHOSEN = 2'd2;
    localparam logic [1:0] ACT_EXIT   = 2'd3;

    typedef enum logic [2:0] {IDLE, EVAL, OFFER_ALT, COMMIT, DENY} state_t;

    state_t          state, state_nxt;
    logic [1:0]      mode_q;
    logic            flr_q, spec_q, exit_q;
    logic [1:0]      act_q, act_nxt;
    logic [TO_W-1:0] to_cnt;

    // Next-state and pending-action decision
    always_comb begin
        state_nxt = state;
        act_nxt   = act_q;
        case (state)
            IDLE: if (submit) state_nxt = EVAL;
            EVAL: begin
                if (mode_q == 2'd0) begin
                    if (id_special) begin
                        if (remain_flr_spec_0 != '0) begin
                            state_nxt = COMMIT;
                            act_nxt   = ACT_CHOSEN;
                        end else begin
                            state_nxt = DENY;
                        end
                    end else if (id_valid) begin
                        if (!chosen_flr_full) begin
                            state_nxt = COMMIT;
                            act_nxt   = ACT_CHOSEN;
                        end else if (!alternative_flr_full) begin
                            state_nxt = OFFER_ALT;
                        end else begin
                            state_nxt = DENY;
                        end
                    end else begin
                        state_nxt = DENY;
                    end
                end else if (mode_q == 2'd1) begin
                    if (id_valid || id_special) begin
                        state_nxt = COMMIT;
                        act_nxt   = ACT_EXIT;
                    end else begin
                        state_nxt = DENY;
                    end
                end else begin
                    // restrict and the reserved code both refuse the request
                    state_nxt = DENY;
                end
            end
            OFFER_ALT: begin
                // a decline outranks a simultaneous accept; any answer outranks the timeout
                if (decline) begin
                    state_nxt = DENY;
                end else if (accept_alt) begin
                    state_nxt = COMMIT;
                    act_nxt   = ACT_ALT;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = DENY;
                end
            end
            COMMIT:  state_nxt = IDLE;
            DENY:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, request latches, offer timer and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            mode_q       <= 2'd0;
            flr_q        <= 1'b0;
            spec_q       <= 1'b0;
            exit_q       <= 1'b0;
            act_q        <= ACT_NONE;
            to_cnt       <= '0;
            action_taken <= ACT_NONE;
            offer_alt    <= 1'b0;
            denied       <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state <= state_nxt;
            act_q <= act_nxt;
            if (state == IDLE && submit) begin
                mode_q <= MODE;
                flr_q  <= chosen_flr;
            end
            if (state == EVAL) begin
                spec_q <= id_special;
                exit_q <= exit_flr;
            end
            // the timer runs only while the offer is open and restarts from 0 on each entry
            to_cnt       <= (state == OFFER_ALT) ? to_cnt + TO_W'(1) : '0;
            action_taken <= (state_nxt == COMMIT) ? act_nxt : ACT_NONE;
            offer_alt    <= (state_nxt == OFFER_ALT);
            denied       <= (state_nxt == DENY);
            done         <= (state_nxt == COMMIT) || (state_nxt == DENY);
            busy         <= (state_nxt != IDLE);
        end
    end

    // Space accounting on the edge that leaves COMMIT
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            remain_flr_spec_0 <= SPEC_CAP;
            remain_flr_norm_0 <= NORM_CAP;
            remain_flr_1      <= F1_CAP;
        end else if (state == COMMIT) begin
            case (act_q)
                ACT_CHOSEN: begin
                    if (spec_q) begin
                        if (remain_flr_spec_0 != '0) remain_flr_spec_0 <= remain_flr_spec_0 - ONE;
                    end else if (!flr_q) begin
                        if (remain_flr_norm_0 != '0) remain_flr_norm_0 <= remain_flr_norm_0 - ONE;
                    end else begin
                        if (remain_flr_1 != '0) remain_flr_1 <= remain_flr_1 - ONE;
                    end
                end
                ACT_ALT: begin
                    // the user parks on the floor opposite to the one chosen
                    if (flr_q) begin
                        if (remain_flr_norm_0 != '0) remain_flr_norm_0 <= remain_flr_norm_0 - ONE;
                    end else begin
                        if (remain_flr_1 != '0) remain_flr_1 <= remain_flr_1 - ONE;
                    end
                end
                ACT_EXIT: begin
                    if (spec_q) begin
                        if (remain_flr_spec_0 < SPEC_CAP) remain_flr_spec_0 <= remain_flr_spec_0 + ONE;
                    end else if (exit_q) begin
                        if (remain_flr_1 < F1_CAP) remain_flr_1 <= remain_flr_1 + ONE;
                    end else begin
                        if (remain_flr_norm_0 < NORM_CAP) remain_flr_norm_0 <= remain_flr_norm_0 + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_floor_access_controller.sv
// Bench for floor_access_controller. The driver runs whole requests and,
// for each one, predicts the outcome and its cycle timeline from the request
// rules. A single compare process checks every DUT output on every cycle and
// also checks a few hand-computed literal expectations.
module tb_floor_access_controller;

    localparam int NCAP  = 3;
    localparam int SCAP  = 2;
    localparam int F1CAP = 3;
    localparam int W     = 3;
    localparam int TO    = 6;

    localparam int OC_DENY  = 0;
    localparam int OC_C2    = 1;
    localparam int OC_OFFER = 2;
    localparam int OC_C3    = 3;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [1:0]   MODE = 2'd0;
    logic         submit = 1'b0, chosen_flr = 1'b0, id_valid = 1'b0, id_special = 1'b0;
    logic         chosen_flr_full = 1'b0, alternative_flr_full = 1'b0, exit_flr = 1'b0;
    logic         accept_alt = 1'b0, decline = 1'b0;
    logic [1:0]   action_taken;
    logic [W-1:0] remain_flr_spec_0, remain_flr_norm_0, remain_flr_1;
    logic         offer_alt, denied, done, busy;

    floor_access_controller #(
        .FLR0_NORM_CAP(NCAP), .FLR0_SPEC_CAP(SCAP), .FLR1_CAP(F1CAP),
        .CNT_W(W), .TIMEOUT_CYC(TO)
    ) dut (
        .CLK(CLK), .RST(RST), .MODE(MODE), .submit(submit), .chosen_flr(chosen_flr),
        .id_valid(id_valid), .id_special(id_special), .chosen_flr_full(chosen_flr_full),
        .alternative_flr_full(alternative_flr_full), .exit_flr(exit_flr),
        .accept_alt(accept_alt), .decline(decline), .action_taken(action_taken),
        .remain_flr_spec_0(remain_flr_spec_0), .remain_flr_norm_0(remain_flr_norm_0),
        .remain_flr_1(remain_flr_1), .offer_alt(offer_alt), .denied(denied),
        .done(done), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Model state: free spaces and the expected outputs for the current cycle
    int   m_spec, m_norm0, m_f1;
    int   e_act;
    bit   e_offer, e_den, e_done, e_busy;
    bit   chk_en = 1'b0;

    typedef struct {
        string name;
        int    sel;
        int    exp;
    } lit_t;
    lit_t lit_q[$];

    int tests = 0;
    int fails = 0;

    function automatic int sel_val(input int s);
        case (s)
            0:       return int'(action_taken);
            1:       return int'(denied);
            2:       return int'(remain_flr_spec_0);
            3:       return int'(remain_flr_norm_0);
            4:       return int'(remain_flr_1);
            5:       return int'(busy);
            6:       return int'(offer_alt);
            default: return int'(done);
        endcase
    endfunction

    // Compare process: full output vector every cycle, then any queued literals
    initial begin
        int lit_idx;
        int got;
        lit_idx = 0;
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                tests++;
                if (int'(action_taken) != e_act || offer_alt !== e_offer || denied !== e_den ||
                    done !== e_done || busy !== e_busy || int'(remain_flr_spec_0) != m_spec ||
                    int'(remain_flr_norm_0) != m_norm0 || int'(remain_flr_1) != m_f1) begin
                    fails++;
                    $display("FAIL cycle t=%0t act=%0d/%0d offer=%0b/%0b denied=%0b/%0b done=%0b/%0b busy=%0b/%0b spec=%0d/%0d norm0=%0d/%0d f1=%0d/%0d (got/expected)",
                             $time, action_taken, e_act, offer_alt, e_offer, denied, e_den,
                             done, e_done, busy, e_busy, remain_flr_spec_0, m_spec,
                             remain_flr_norm_0, m_norm0, remain_flr_1, m_f1);
                end
            end
            while (lit_idx < lit_q.size()) begin
                tests++;
                got = sel_val(lit_q[lit_idx].sel);
                if (got != lit_q[lit_idx].exp) begin
                    fails++;
                    $display("FAIL %s got %0d expected %0d", lit_q[lit_idx].name, got, lit_q[lit_idx].exp);
                end
                lit_idx++;
            end
        end
    end

    task automatic lit(input string name, input int sel, input int exp);
        lit_t l;
        l.name = name; l.sel = sel; l.exp = exp;
        lit_q.push_back(l);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_exp(input int a, input bit o, input bit dn, input bit dd, input bit b);
        e_act = a; e_offer = o; e_den = dn; e_done = dd; e_busy = b;
    endtask

    task automatic model_reset();
        m_spec = SCAP; m_norm0 = NCAP; m_f1 = F1CAP;
        set_exp(0, 0, 0, 0, 0);
    endtask

    function automatic int dn(input int c);
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic int up(input int c, input int cap);
        return (c < cap) ? c + 1 : cap;
    endfunction

    // Outcome of evaluation from the request rules
    function automatic int outcome(input int mode, input bit valid, input bit special,
                                   input bit cff, input bit aff);
        if (mode == 0) begin
            if (special) return (m_spec > 0) ? OC_C2 : OC_DENY;
            if (valid) begin
                if (!cff) return OC_C2;
                if (!aff) return OC_OFFER;
            end
            return OC_DENY;
        end
        if (mode == 1) return (valid || special) ? OC_C3 : OC_DENY;
        return OC_DENY;
    endfunction

    // Space bookkeeping of a committed request
    task automatic apply(input int act, input bit special, input bit flr, input bit exf);
        case (act)
            2: if (special) m_spec = dn(m_spec);
               else if (!flr) m_norm0 = dn(m_norm0);
               else m_f1 = dn(m_f1);
            1: if (!flr) m_f1 = dn(m_f1);
               else m_norm0 = dn(m_norm0);
            3: if (special) m_spec = up(m_spec, SCAP);
               else if (exf) m_f1 = up(m_f1, F1CAP);
               else m_norm0 = up(m_norm0, NCAP);
            default: ;
        endcase
    endtask

    // One request. Starts in an idle cycle and returns in the idle cycle that follows it.
    // ans_kind: bit0 accept, bit1 decline; answered on offer cycle ans_at (1-based).
    // rst_at: offer cycle on which reset is pulsed (0 = never).
    task automatic txn(input int mode, input bit flr, input bit valid, input bit special,
                       input bit cff, input bit aff, input bit exf,
                       input int ans_kind, input int ans_at, input int rst_at,
                       input int lit_act, input int lit_den, input string tag);
        int oc, k, act;
        bit leave, commit;
        // cycle 0: request strobe
        MODE = 2'(mode); chosen_flr = flr; id_valid = valid; id_special = special;
        chosen_flr_full = cff; alternative_flr_full = aff; exit_flr = exf;
        submit = 1'b1; accept_alt = 1'b0; decline = 1'b0;
        set_exp(0, 0, 0, 0, 0);
        oc = outcome(mode, valid, special, cff, aff);
        commit = 1'b0; act = 0;
        if (oc == OC_C2) begin commit = 1'b1; act = 2; end
        if (oc == OC_C3) begin commit = 1'b1; act = 3; end
        // cycle 1: evaluation; MODE and stray strobes must not matter
        cyc();
        submit = 1'($urandom); MODE = 2'($urandom);
        accept_alt = 1'($urandom); decline = 1'($urandom);
        set_exp(0, 0, 0, 0, 1);
        if (oc == OC_OFFER) begin
            k = 0; leave = 1'b0;
            while (!leave) begin
                cyc();
                k++;
                submit = 1'($urandom); accept_alt = 1'b0; decline = 1'b0;
                set_exp(0, 1, 0, 0, 1);
                if (rst_at == k) begin
                    RST = 1'b1;
                    model_reset();
                    cyc();
                    RST = 1'b0; submit = 1'b0;
                    set_exp(0, 0, 0, 0, 0);
                    return;
                end
                if (ans_kind != 0 && ans_at == k) begin
                    accept_alt = ans_kind[0]; decline = ans_kind[1];
                    if (!ans_kind[1]) begin commit = 1'b1; act = 1; end
                    leave = 1'b1;
                end else if (k == TO) begin
                    leave = 1'b1;
                end
            end
        end
        // result cycle
        cyc();
        submit = 1'($urandom); accept_alt = 1'($urandom); decline = 1'($urandom);
        set_exp(commit ? act : 0, 0, !commit, 1, 1);
        if (lit_act >= 0) lit({tag, "_action"}, 0, lit_act);
        if (lit_den >= 0) lit({tag, "_denied"}, 1, lit_den);
        // following idle cycle: counters updated
        cyc();
        submit = 1'b0; accept_alt = 1'b0; decline = 1'b0;
        if (commit) apply(act, special, flr, exf);
        set_exp(0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            cyc();
            submit = 1'b0; MODE = 2'($urandom);
            accept_alt = 1'($urandom); decline = 1'($urandom);
            set_exp(0, 0, 0, 0, 0);
        end
        accept_alt = 1'b0; decline = 1'b0;
    endtask

    initial begin
        int r, md;
        model_reset();
        #2 RST = 1'b1;
        chk_en = 1'b1;
        cyc(); cyc();
        RST = 1'b0;
        lit("rst_spec", 2, 2); lit("rst_norm0", 3, 3); lit("rst_f1", 4, 3);
        lit("rst_action", 0, 0); lit("rst_busy", 5, 0);
        idle(1);

        // normal valid ID onto floor 1
        txn(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, "direct");
        lit("direct_f1", 4, 2);
        // alternative offer accepted on the 5th offer cycle
        txn(0, 0, 1, 0, 1, 0, 0, 1, 5, 0, 1, 0, "alt");
        lit("alt_f1", 4, 1); lit("alt_norm0", 3, 3);
        // special pool exhaustion
        txn(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, "spec1");
        txn(0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 2, 0, "spec2");
        lit("spec2_cnt", 2, 0);
        txn(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "spec3");
        lit("spec3_cnt", 2, 0);
        // unanswered offer, then both answers at once
        txn(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, "timeout");
        txn(0, 1, 1, 0, 1, 0, 0, 3, 2, 0, 0, 1, "both");
        // enter floor 0 then leave from floor 0, then an extra exit at capacity
        txn(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, "enter0");
        lit("enter0_norm0", 3, 2);
        txn(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, "exit0");
        lit("exit0_norm0", 3, 3);
        txn(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, "exit_sat");
        lit("exit_sat_norm0", 3, 3);
        // restrict and reserved modes
        txn(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "restrict");
        txn(3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, "reserved");
        // reset while the offer is open
        txn(0, 0, 1, 0, 1, 0, 0, 0, 0, 3, -1, -1, "rst_offer");
        lit("rst_offer_busy", 5, 0); lit("rst_offer_offer", 6, 0); lit("rst_offer_f1", 4, 3);
        idle(2);

        // randomized requests, occasionally back to back
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 7));
            md = (r < 4) ? 0 : (r < 6) ? 1 : (r - 4);
            txn(md, 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(1, TO + 1)),
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, TO)) : 0,
                -1, -1, "rnd");
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end

        cyc();
        @(negedge CLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/floor_access_controller.md
# floor_access_controller

Transaction controller for the two-floor parking access system. It receives the identity/capacity flags from the floor ID lookup logic and runs each enter/exit request through a handshake with the user. It generates `action_taken` to commit the request and owns the three remaining-space counters that the lookup logic consumes.

## Interface
- `FLR0_NORM_CAP`, 3: normal spaces on floor 0.
- `FLR0_SPEC_CAP`, 2: special spaces on floor 0.
- `FLR1_CAP`, 3: spaces on floor 1.
- `CNT_W`, 3: counter width; every CAP must be ≤ 2^CNT_W−1.
- `TIMEOUT_CYC`, 255: cycles allowed in OFFER_ALT before an automatic deny; must be ≥ 1.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `MODE`  in  2  0 = enter, 1 = exit, 2 = restrict, 3 = reserved (treated as restrict).
- `submit`  in  1  one-cycle request strobe; ID and `chosen_flr` stay stable until `done`.
- `chosen_flr`  in  1  0 = floor 0, 1 = floor 1.
- `id_valid`, `id_special`  in  1 each  lookup result for the presented ID.
- `chosen_flr_full`, `alternative_flr_full`  in  1 each  capacity flags from lookup.
- `exit_flr`  in  1  floor on which the exiting normal user is parked.
- `accept_alt`, `decline`  in  1 each  user answer to the alternative-floor offer.
- `action_taken`  out  2  0 = none, 1 = alternative floor, 2 = chosen floor, 3 = exit.
- `remain_flr_spec_0`, `remain_flr_norm_0`, `remain_flr_1`  out  CNT_W each  free spaces.
- `offer_alt`  out  1  high while waiting for the user's answer.
- `denied`  out  1  one-cycle pulse when a request is rejected.
- `done`  out  1  one-cycle pulse at the end of every request (commit or deny).
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, EVAL, OFFER_ALT, COMMIT, DENY.
- IDLE:
  - On `submit`, latch `MODE` and `chosen_flr` into `mode_q` and `flr_q`, then go to EVAL.
  - `submit` is ignored in every other state.
- EVAL, enter (`mode_q` = 0):
  - `id_special` takes priority: if `remain_flr_spec_0` > 0, go to COMMIT with action 2; else go to DENY.
  - Else if `id_valid`:
    - `!chosen_flr_full`: COMMIT with action 2.
    - `chosen_flr_full` and `!alternative_flr_full`: go to OFFER_ALT.
    - Both full: go to DENY.
  - Neither flag set: go to DENY.
- EVAL, exit (`mode_q` = 1): `id_valid` or `id_special` set goes to COMMIT with action 3; otherwise go to DENY.
- EVAL, `mode_q` ≥ 2: go to DENY.
- OFFER_ALT:
  - `offer_alt` = 1; the timeout counter loads 0 on entry.
  - `decline` goes to DENY. If `decline` and `accept_alt` are high in the same cycle, `decline` wins.
  - `accept_alt` goes to COMMIT with action 1.
  - When the counter reaches TIMEOUT_CYC−1 with no answer, go to DENY.
- COMMIT: `action_taken` = latched action and `done` = 1 for exactly one cycle, then go to IDLE.
- DENY: `denied` = 1 and `done` = 1 for one cycle, then go to IDLE.
- Counter updates happen on the clock edge that ends COMMIT:
  - Action 2, special user: `remain_flr_spec_0` −1.
  - Action 2, normal user, `flr_q` = 0: `remain_flr_norm_0` −1. With `flr_q` = 1: `remain_flr_1` −1.
  - Action 1: decrement the opposite floor's normal counter.
  - Action 3, special user: `remain_flr_spec_0` +1.
  - Action 3, normal user: +1 on the counter selected by `exit_flr`.
- Arithmetic rules:
  - A decrement of a counter already at 0 is suppressed (EVAL should already have denied).
  - Increments saturate at the CAP.
  - Special and normal floor-0 pools are independent.

## Timing
- Reset values: state = IDLE, `remain_*` = the respective CAPs, `action_taken` = 0, and `offer_alt`, `denied`, `done`, `busy` all 0.
- Reset mid-transaction aborts the request without any counter change.
- All outputs are registered.
- Direct commit: `submit` at cycle 0; EVAL at cycle 1; `action_taken` valid in cycle 2; updated counter visible from cycle 3.
- Deny path: `denied` in cycle 2.
- Alternative path: `offer_alt` from cycle 2; answer sampled at cycle n puts `action_taken`/`denied` in cycle n+1.
- Timeout path: with no answer, `denied` asserts TIMEOUT_CYC cycles after `offer_alt` rises.
- `MODE` changing after `submit` has no effect on the current request.
- `busy` rises the cycle after `submit` and falls in the cycle after `done`.

## Test plan
- Reset, then a normal valid ID enters with `chosen_flr` = 1 and no full flags → `action_taken` = 2 in cycle 2; `remain_flr_1` goes 3→2 in cycle 3.
- `chosen_flr` = 0, `chosen_flr_full` = 1, `alternative_flr_full` = 0, then `accept_alt` on the 5th cycle of OFFER_ALT → `action_taken` = 1; `remain_flr_1` −1 and `remain_flr_norm_0` unchanged.
- Special ID entered three times with `FLR0_SPEC_CAP` = 2 → two commits, spec count reaches 0; third request gives `denied` with counter stuck at 0.
- Offer with no answer and `TIMEOUT_CYC` = 4 → `denied` exactly 4 cycles after `offer_alt` rises; `accept_alt`+`decline` together → `denied`.
- Exit of a normal user with `exit_flr` = 0 after one entry → `action_taken` = 3 and `remain_flr_norm_0` back to 3. Extra exits at CAP stay saturated at 3.
- `MODE` = 2 with `submit` → `denied`. Separately, assert `RST` during OFFER_ALT → all outputs return to reset values with no counter change.
